// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer around one external ALU bit slice.
//
// Runs a WIDTH-bit operation through a single-bit slice, LSB first, one bit per
// clock. The ripple carry lives in a flop between cycles and the result word is
// assembled in a shift register.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   start, op, a_in, b_in   request, opcode and operands (captured in IDLE)
//   slice_a/b/cin/c         operand bits, carry and opcode driven to the slice
//   slice_f, slice_cout     slice function and carry outputs
//   result, carry_out, zero assembled result and flags, held until next start
//   busy, done              busy in RUN/DONE, done pulses for one cycle
//
// Optional feature macro: ALU_SERIAL_OVF_EN adds a signed-overflow output
// (overflow) for add/sub.

module alu_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_c,
  input  logic             slice_f,
  input  logic             slice_cout,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
`ifdef ALU_SERIAL_OVF_EN
  output logic             overflow,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             arith;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Only add (000) and sub (001) produce a meaningful carry.
  assign arith = (op_q[2:1] == 2'b00);

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    op_d        = op_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
`ifdef ALU_SERIAL_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d      = a_in;
          b_sh_d      = b_in;
          op_d        = op;
          // Subtract is a + ~b + 1: the +1 enters as the initial carry.
          carry_d     = (op == 3'b001);
          cnt_d       = '0;
          carry_out_d = 1'b0;
          zero_d      = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
          ovf_d       = 1'b0;
`endif
          state_d     = StRun;
        end
      end
      StRun: begin
        result_d = {slice_f, result_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last bit: flags latch here so they are valid throughout DONE.
          carry_out_d = arith & slice_cout;
          zero_d      = (result_d == '0);
`ifdef ALU_SERIAL_OVF_EN
          // carry_q is the carry into the MSB at this edge.
          ovf_d       = arith & (carry_q ^ slice_cout);
`endif
          state_d     = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Slice inputs are forced to 0 outside RUN so the slice sees a quiet bus.
  assign slice_a   = (state_q == StRun) & a_sh_q[0];
  assign slice_b   = (state_q == StRun) & b_sh_q[0];
  assign slice_cin = (state_q == StRun) & carry_q;
  assign slice_c   = (state_q == StRun) ? op_q : 3'b000;

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
`ifdef ALU_SERIAL_OVF_EN
  assign overflow  = ovf_q;
`endif
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: randomized self-checking bench for alu_serial_seq.
// A behavioural ALU bit slice is attached to the sequencer; word-level results
// are predicted with plain arithmetic on the whole operands.

module tb_alu_serial_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         slice_a, slice_b, slice_cin, slice_f, slice_cout;
  logic [2:0]   slice_c;
  logic [W-1:0] result;
  logic         carry_out, zero, busy, done;
`ifdef ALU_SERIAL_OVF_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_serial_seq #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a_in       (a_in),
    .b_in       (b_in),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_c    (slice_c),
    .slice_f    (slice_f),
    .slice_cout (slice_cout),
    .result     (result),
    .carry_out  (carry_out),
    .zero       (zero),
`ifdef ALU_SERIAL_OVF_EN
    .overflow   (overflow),
`endif
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU bit slice. Logic ops also produce a carry so masking is exercised.
  logic b_eff;
  always_comb begin
    b_eff = slice_b ^ (slice_c == 3'b001 || slice_c == 3'b011 || slice_c == 3'b101);
    case (slice_c)
      3'b000, 3'b001: slice_f = slice_a ^ b_eff ^ slice_cin;
      3'b010, 3'b011: slice_f = slice_a | b_eff;
      3'b100, 3'b101: slice_f = slice_a & b_eff;
      3'b110:         slice_f = ~slice_a;
      default:        slice_f = ~slice_b;
    endcase
    slice_cout = (slice_a & b_eff) | (slice_a & slice_cin) | (b_eff & slice_cin);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: result, carry and signed overflow.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0]   s;
    logic [W-1:0] bb;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        bb = (o == 3'd1) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + ((o == 3'd1) ? (W+1)'(1) : (W+1)'(0));
        r  = s[W-1:0];
        c  = s[W];
        v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2:    r = a | b;
      3'd3:    r = a | ~b;
      3'd4:    r = a & b;
      3'd5:    r = a & ~b;
      3'd6:    r = ~a;
      default: r = ~b;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke_start);
    logic [W-1:0] er;
    logic         ec, ev;
    int           cyc;
    model(o, a, b, er, ec, ev);
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    op    = 3'($urandom);
    check_eq("zero_cleared", 32'(zero), 0);
    check_eq("cout_cleared", 32'(carry_out), 0);
    cyc = 0;
    while (!done && cyc < int'(W) + 4) begin
      check_eq("busy_run", 32'(busy), 1);
      if (cyc < int'(W)) begin
        check_eq("slice_a", 32'(slice_a), 32'(a[cyc]));
        check_eq("slice_b", 32'(slice_b), 32'(b[cyc]));
        check_eq("slice_c", 32'(slice_c), 32'(o));
      end
      if (poke_start && cyc == 2) begin
        start = 1'b1;
        a_in  = ~a;
        b_in  = ~b;
      end
      if (cyc == 4) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check_eq("done_latency", 32'(cyc), 32'(W));
    check_eq("busy_done", 32'(busy), 1);
    check_eq("result", 32'(result), 32'(er));
    check_eq("carry_out", 32'(carry_out), 32'(ec));
    check_eq("zero", 32'(zero), 32'(er == '0));
`ifdef ALU_SERIAL_OVF_EN
    check_eq("overflow", 32'(overflow), 32'(ev));
`endif
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(done), 0);
    check_eq("busy_idle", 32'(busy), 0);
    check_eq("result_hold", 32'(result), 32'(er));
    check_eq("cout_hold", 32'(carry_out), 32'(ec));
    check_eq("zero_hold", 32'(zero), 32'(er == '0));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_result"}, 32'(result), 0);
    check_eq({tag, "_cout"}, 32'(carry_out), 0);
    check_eq({tag, "_zero"}, 32'(zero), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_slice"}, 32'({slice_a, slice_b, slice_cin, slice_c}), 0);
`ifdef ALU_SERIAL_OVF_EN
    check_eq({tag, "_ovf"}, 32'(overflow), 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a_in  = '0;
    b_in  = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(3'b000, 8'h3C, 8'h05, 1'b0);
    run_op(3'b001, 8'h06, 8'h05, 1'b0);
    run_op(3'b001, 8'h05, 8'h06, 1'b0);
    run_op(3'b000, 8'hFF, 8'h01, 1'b0);
    run_op(3'b000, 8'h7F, 8'h01, 1'b0);
    run_op(3'b100, 8'hF0, 8'h3C, 1'b0);
    run_op(3'b110, 8'h0F, 8'h00, 1'b0);
    run_op(3'b011, 8'h00, 8'hF0, 1'b0);
    run_op(3'b101, 8'hFF, 8'h0F, 1'b0);
    run_op(3'b111, 8'h12, 8'h5A, 1'b0);
    // A second start during RUN must be ignored.
    run_op(3'b000, 8'h21, 8'h13, 1'b1);

    // Reset after four bits of an add.
    @(negedge clk);
    op = 3'b000; a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 8'h01, 8'h01, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
